// File: rtl/pingpong_buf_pkg.sv
// Shared types and default sizes for the ping-pong line buffer.
// Holds the per-bank state enum and the default word/address widths.
package pingpong_buf_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 13;

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_FULL  = 2'd2,
        BANK_DRAIN = 2'd3
    } bank_state_e;

endpackage

// File: rtl/sdp_ram_1clk.sv
// Single-clock simple dual-port RAM, one-cycle registered read, inferred.
// Ports: i_clk; write i_we/i_waddr/i_wdata; read i_re/i_raddr -> o_rdata.
module sdp_ram_1clk
    import pingpong_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W + 1
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Read register only loads on a read, so o_rdata holds between reads.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/pingpong_line_buf.sv
// Two-bank ping-pong line buffer: writer fills one bank while reader drains the other.
// Ports: clk_ref, sys_rst_n; write wr_*; read rd_*; drop_cnt counts rejected writes.
module pingpong_line_buf
    import pingpong_buf_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter bit OUT_REG = 1'b1
) (
    input  logic              clk_ref,
    input  logic              sys_rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_commit,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_release,
    output logic              rd_avail,
    output logic [ADDR_W:0]   rd_len,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld,
    output logic [15:0]       drop_cnt
);

    localparam logic [ADDR_W:0] L_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    bank_state_e     r_state [2];
    logic [ADDR_W:0] r_cnt   [2];
    logic [ADDR_W:0] r_len   [2];
    logic            r_wr_sel;
    logic            r_rd_sel;
    logic [15:0]     r_drop;
    logic            r_vld1;

    bank_state_e       w_wr_st;
    bank_state_e       w_rd_st;
    logic [ADDR_W:0]   w_cur;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic [ADDR_W:0]   w_len_nxt;
    logic              w_wr_acc;
    logic              w_commit;
    logic              w_rd_iss;
    logic              w_rel;
    logic [DATA_W-1:0] w_ram_q;

    assign w_wr_st  = r_state[r_wr_sel];
    assign w_rd_st  = r_state[r_rd_sel];
    assign wr_ready = (w_wr_st == BANK_EMPTY) || (w_wr_st == BANK_FILL);
    assign rd_avail = (w_rd_st == BANK_FULL) || (w_rd_st == BANK_DRAIN);
    assign rd_len   = r_len[r_rd_sel];
    assign drop_cnt = r_drop;

    assign w_wr_acc  = wr_en && wr_ready;
    assign w_cur     = r_cnt[r_wr_sel];
    assign w_cnt_nxt = (w_cur == L_DEPTH) ? w_cur : w_cur + 1'b1;
    // A write in the commit cycle lands first and counts toward the length.
    assign w_len_nxt = w_wr_acc ? w_cnt_nxt : w_cur;
    assign w_commit  = wr_commit &&
                       ((w_wr_st == BANK_FILL) ||
                        ((w_wr_st == BANK_EMPTY) && w_wr_acc));
    assign w_rd_iss  = rd_en && rd_avail && sys_rst_n;
    assign w_rel     = rd_release && rd_avail;

    // Writer bank needs EMPTY/FILL and reader bank FULL/DRAIN, so the
    // write/commit and read/release updates never hit the same bank.
    always_ff @(posedge clk_ref) begin
        if (!sys_rst_n) begin
            for (int b = 0; b < 2; b++) begin
                r_state[b] <= BANK_EMPTY;
                r_cnt[b]   <= '0;
                r_len[b]   <= '0;
            end
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_drop   <= '0;
        end else begin
            if (w_wr_acc) begin
                r_cnt[r_wr_sel] <= w_cnt_nxt;
                if (w_wr_st == BANK_EMPTY) begin
                    r_state[r_wr_sel] <= BANK_FILL;
                end
            end
            if (wr_en && !wr_ready && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
            if (w_commit) begin
                r_state[r_wr_sel] <= BANK_FULL;
                r_len[r_wr_sel]   <= w_len_nxt;
                r_wr_sel          <= ~r_wr_sel;
            end
            if (w_rd_iss && (w_rd_st == BANK_FULL)) begin
                r_state[r_rd_sel] <= BANK_DRAIN;
            end
            if (w_rel) begin
                r_state[r_rd_sel] <= BANK_EMPTY;
                r_cnt[r_rd_sel]   <= '0;
                r_rd_sel          <= ~r_rd_sel;
            end
        end
    end

    // Bank select is the RAM address MSB.
    sdp_ram_1clk #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W + 1)
    ) u_ram (
        .i_clk   (clk_ref),
        .i_we    (w_wr_acc && sys_rst_n),
        .i_waddr ({r_wr_sel, wr_addr}),
        .i_wdata (wr_data),
        .i_re    (w_rd_iss),
        .i_raddr ({r_rd_sel, rd_addr}),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk_ref) begin
        if (!sys_rst_n) begin
            r_vld1 <= 1'b0;
        end else begin
            r_vld1 <= w_rd_iss;
        end
    end

    if (OUT_REG) begin : g_oreg
        logic [DATA_W-1:0] r_dout;
        logic              r_vld2;

        always_ff @(posedge clk_ref) begin
            if (!sys_rst_n) begin
                r_dout <= '0;
                r_vld2 <= 1'b0;
            end else begin
                r_vld2 <= r_vld1;
                if (r_vld1) begin
                    r_dout <= w_ram_q;
                end
            end
        end

        assign rd_data     = r_dout;
        assign rd_data_vld = r_vld2;
    end else begin : g_noreg
        // RAM read register is not reset; mask it to zero until a read
        // has been issued since the last reset.
        logic r_q_ok;

        always_ff @(posedge clk_ref) begin
            if (!sys_rst_n) begin
                r_q_ok <= 1'b0;
            end else if (w_rd_iss) begin
                r_q_ok <= 1'b1;
            end
        end

        assign rd_data     = r_q_ok ? w_ram_q : '0;
        assign rd_data_vld = r_vld1;
    end

endmodule
